// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared types for the DDR read-port arbiter: widths, FSM states, requester ids.
package ap_ddr_pkg;

    localparam int DDR_ADDR_WIDTH = 28;
    localparam int DDR_DATA_WIDTH = 64;
    localparam int ISA_WIDTH      = 30;
    localparam int LEN_WIDTH      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_ISA  = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

endpackage

// File: rtl/ddr_rd_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the side that did not win last time goes.
module rr_arb2
    import ap_ddr_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_grant,
    output logic       gnt_valid,
    output req_id_e    gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_ISA;
        if (&req) begin
            gnt_id = (last_grant == REQ_DATA) ? REQ_ISA : REQ_DATA;
        end else if (req[1]) begin
            gnt_id = REQ_DATA;
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Shares one DDR read-burst port between the instruction and data caches,
// one burst per grant, beats and running count returned to the winner only.
module ddr_rd_arbiter
    import ap_ddr_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ISA_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    input  logic [LEN_WIDTH-1:0]      isa_read_len,
    output logic [ISA_WIDTH-1:0]      instruction_to_cache,
    output logic [LEN_WIDTH-1:0]      rd_cnt_isa,
    output logic                      isa_data_valid,
    input  logic                      data_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] data_read_addr,
    input  logic [LEN_WIDTH-1:0]      data_read_len,
    output logic [DDR_DATA_WIDTH-1:0] data_to_cache,
    output logic [LEN_WIDTH-1:0]      rd_cnt_data,
    output logic                      data_data_valid,
    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [LEN_WIDTH-1:0]      rd_burst_len,
    input  logic                      rd_burst_data_valid,
    input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    input  logic                      rd_burst_finish,
    output logic                      grant_isa
);

    state_e                      state_q, state_d;
    req_id_e                     winner_q, winner_d;
    req_id_e                     last_grant_q, last_grant_d;
    logic [DDR_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic                        abort_q, abort_d;
    logic                        rd_burst_req_q, rd_burst_req_d;
    logic                        grant_isa_q, grant_isa_d;
    logic                        isa_valid_q, isa_valid_d;
    logic                        data_valid_q, data_valid_d;
    logic [ISA_WIDTH-1:0]        isa_instr_q, isa_instr_d;
    logic [DDR_DATA_WIDTH-1:0]   data_beat_q, data_beat_d;
    logic [LEN_WIDTH-1:0]        cnt_isa_q, cnt_isa_d;
    logic [LEN_WIDTH-1:0]        cnt_data_q, cnt_data_d;

    logic                        gnt_valid;
    req_id_e                     gnt_id;
    logic                        win_req;
    logic [LEN_WIDTH-1:0]        win_cnt;
    logic [LEN_WIDTH-1:0]        cnt_inc;
    logic                        beat_ok;
    logic                        ddr_resp;

    // Zero-length requests never compete for the port.
    rr_arb2 u_rr_arb2 (
        .req        ({data_read_req & (data_read_len != '0),
                      ISA_read_req  & (isa_read_len  != '0)}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign win_req  = (winner_q == REQ_ISA) ? ISA_read_req : data_read_req;
    assign win_cnt  = (winner_q == REQ_ISA) ? cnt_isa_q : cnt_data_q;
    assign cnt_inc  = win_cnt + LEN_WIDTH'(1);
    assign beat_ok  = rd_burst_data_valid & win_req & ~abort_q & (win_cnt < len_q);
    assign ddr_resp = rd_burst_data_valid | rd_burst_finish;

    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        last_grant_d   = last_grant_q;
        addr_d         = addr_q;
        len_d          = len_q;
        abort_d        = abort_q;
        rd_burst_req_d = rd_burst_req_q;
        isa_valid_d    = 1'b0;
        data_valid_d   = 1'b0;
        isa_instr_d    = isa_instr_q;
        data_beat_d    = data_beat_q;
        cnt_isa_d      = cnt_isa_q;
        cnt_data_d     = cnt_data_q;

        unique case (state_q)
            IDLE: begin
                rd_burst_req_d = 1'b0;
                if (gnt_valid) begin
                    winner_d = gnt_id;
                    abort_d  = 1'b0;
                    state_d  = ISSUE;
                    if (gnt_id == REQ_ISA) begin
                        addr_d    = ISA_read_addr;
                        len_d     = isa_read_len;
                        cnt_isa_d = '0;
                    end else begin
                        addr_d     = data_read_addr;
                        len_d      = data_read_len;
                        cnt_data_d = '0;
                    end
                end
            end
            ISSUE, BURST: begin
                if (state_q == ISSUE) begin
                    rd_burst_req_d = ~ddr_resp;
                    if (ddr_resp) state_d = BURST;
                end
                if (!win_req) begin
                    abort_d = 1'b1;
                    if (winner_q == REQ_ISA) cnt_isa_d = '0;
                    else cnt_data_d = '0;
                end
                if (beat_ok) begin
                    if (winner_q == REQ_ISA) begin
                        isa_valid_d = 1'b1;
                        isa_instr_d = rd_burst_data[ISA_WIDTH-1:0];
                        cnt_isa_d   = cnt_inc;
                    end else begin
                        data_valid_d = 1'b1;
                        data_beat_d  = rd_burst_data;
                        cnt_data_d   = cnt_inc;
                    end
                end
                // An abandoned burst must still drain: DDR cannot abort.
                if (abort_d) begin
                    if (rd_burst_finish) begin
                        state_d        = IDLE;
                        last_grant_d   = winner_q;
                        abort_d        = 1'b0;
                        rd_burst_req_d = 1'b0;
                    end
                end else if (rd_burst_finish || (beat_ok && cnt_inc == len_q)) begin
                    state_d        = DONE;
                    rd_burst_req_d = 1'b0;
                end
            end
            DONE: begin
                if (!win_req) begin
                    state_d      = IDLE;
                    last_grant_d = winner_q;
                    if (winner_q == REQ_ISA) cnt_isa_d = '0;
                    else cnt_data_d = '0;
                end
            end
        endcase

        grant_isa_d = (state_d != IDLE) && (winner_d == REQ_ISA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            winner_q       <= REQ_ISA;
            last_grant_q   <= REQ_DATA;
            addr_q         <= '0;
            len_q          <= '0;
            abort_q        <= 1'b0;
            rd_burst_req_q <= 1'b0;
            grant_isa_q    <= 1'b0;
            isa_valid_q    <= 1'b0;
            data_valid_q   <= 1'b0;
            isa_instr_q    <= '0;
            data_beat_q    <= '0;
            cnt_isa_q      <= '0;
            cnt_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            last_grant_q   <= last_grant_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            abort_q        <= abort_d;
            rd_burst_req_q <= rd_burst_req_d;
            grant_isa_q    <= grant_isa_d;
            isa_valid_q    <= isa_valid_d;
            data_valid_q   <= data_valid_d;
            isa_instr_q    <= isa_instr_d;
            data_beat_q    <= data_beat_d;
            cnt_isa_q      <= cnt_isa_d;
            cnt_data_q     <= cnt_data_d;
        end
    end

    assign instruction_to_cache = isa_instr_q;
    assign rd_cnt_isa           = cnt_isa_q;
    assign isa_data_valid       = isa_valid_q;
    assign data_to_cache        = data_beat_q;
    assign rd_cnt_data          = cnt_data_q;
    assign data_data_valid      = data_valid_q;
    assign rd_burst_req         = rd_burst_req_q;
    assign rd_burst_addr        = addr_q;
    assign rd_burst_len         = len_q;
    assign grant_isa            = grant_isa_q;

endmodule
